// File: rtl/keypad_entry_buffer_if.sv
// Keypad entry bundle: raw one-hot key input toward the buffer and the
// decoded digit/status outputs coming back from it.
interface keypad_entry_buffer_if #(
    parameter int NUM_DIGITS = 3
);
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic [15:0]             onehot;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [CW-1:0]           count;
    logic                    key_valid;
    logic [3:0]              key_code;
    logic                    full;
    logic                    entered;

    modport master (
        output onehot,
        input  digits,
        input  count,
        input  key_valid,
        input  key_code,
        input  full,
        input  entered
    );

    modport slave (
        input  onehot,
        output digits,
        output count,
        output key_valid,
        output key_code,
        output full,
        output entered
    );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Debounced 16-key keypad decoder feeding a small digit entry buffer with
// clear, backspace and enter, in either fixed-position or calculator-shift style.
module keypad_entry_buffer #(
    parameter int NUM_DIGITS      = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SHIFT_MODE      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_entry_buffer_if.slave  bus
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int W  = 4 * NUM_DIGITS;

    localparam logic [W-1:0]  ALL_BLANK  = {W{1'b1}};
    localparam logic [W-1:0]  TOP_BLANK  = ~(ALL_BLANK >> 4);
    localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_DIGITS);
    localparam logic [7:0]    DEB_LIMIT  = 8'(DEBOUNCE_CYCLES);

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HOLD
    } state_t;

    state_t        state, state_next;
    logic [15:0]   cand, cand_next;
    logic [7:0]    deb_cnt, deb_next;
    logic          accept;

    logic [W-1:0]  digits_q, digits_next;
    logic [CW-1:0] count_q, count_next;
    logic [3:0]    code_q, code_next;
    logic          valid_q;
    logic          entered_q, entered_next;
    logic          pend_clear_q, pend_clear_next;

    logic [4:0]    dec_in;
    logic [3:0]    acc_code;
    logic [W-1:0]  work_digits;
    logic [CW-1:0] work_count;

    // Bit 4 flags a recognised key; unused keypad positions and chords decode to nothing.
    function automatic logic [4:0] decode_key(input logic [15:0] p);
        case (p)
            16'h0008: decode_key = 5'h10;
            16'h0080: decode_key = 5'h11;
            16'h0040: decode_key = 5'h12;
            16'h0020: decode_key = 5'h13;
            16'h0800: decode_key = 5'h14;
            16'h0400: decode_key = 5'h15;
            16'h0200: decode_key = 5'h16;
            16'h8000: decode_key = 5'h17;
            16'h4000: decode_key = 5'h18;
            16'h2000: decode_key = 5'h19;
            16'h0001: decode_key = {1'b1, KEY_CLEAR};
            16'h0002: decode_key = {1'b1, KEY_BACK};
            16'h0004: decode_key = {1'b1, KEY_ENTER};
            default:  decode_key = 5'h00;
        endcase
    endfunction

    assign dec_in   = decode_key(bus.onehot);
    assign acc_code = dec_in[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cand    <= '0;
            deb_cnt <= '0;
        end else begin
            state   <= state_next;
            cand    <= cand_next;
            deb_cnt <= deb_next;
        end
    end

    // Accept fires on the sample that completes the stable run; the key then
    // has to be released before anything else is considered.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        deb_next   = deb_cnt;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (dec_in[4]) begin
                    cand_next = bus.onehot;
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept     = 1'b1;
                        deb_next   = '0;
                        state_next = HOLD;
                    end else begin
                        deb_next   = 8'd1;
                        state_next = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (bus.onehot == cand) begin
                    if (deb_cnt + 8'd1 == DEB_LIMIT) begin
                        accept     = 1'b1;
                        deb_next   = '0;
                        state_next = HOLD;
                    end else begin
                        deb_next   = deb_cnt + 8'd1;
                    end
                end else begin
                    deb_next   = '0;
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (bus.onehot == 16'h0000) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                deb_next   = '0;
            end
        endcase
    end

    // In shift mode slot 0 is always the newest digit, so both backspace
    // styles remove the most recently entered digit.
    always_comb begin
        digits_next     = digits_q;
        count_next      = count_q;
        code_next       = code_q;
        entered_next    = 1'b0;
        pend_clear_next = pend_clear_q;
        work_digits     = digits_q;
        work_count      = count_q;
        if (accept) begin
            code_next = acc_code;
            if (acc_code <= 4'd9) begin
                if (pend_clear_q) begin
                    work_digits = ALL_BLANK;
                    work_count  = '0;
                end
                pend_clear_next = 1'b0;
                if (SHIFT_MODE != 0) begin
                    work_digits = (work_digits << 4) | W'(acc_code);
                end else begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (work_count < FULL_COUNT && k == int'(work_count)) begin
                            work_digits[4*k +: 4] = acc_code;
                        end
                    end
                end
                if (work_count < FULL_COUNT) begin
                    work_count = work_count + CW'(1);
                end
                digits_next = work_digits;
                count_next  = work_count;
            end else begin
                case (acc_code)
                    KEY_CLEAR: begin
                        digits_next     = ALL_BLANK;
                        count_next      = '0;
                        pend_clear_next = 1'b0;
                    end
                    KEY_BACK: begin
                        if (count_q != '0) begin
                            if (SHIFT_MODE != 0) begin
                                digits_next = (digits_q >> 4) | TOP_BLANK;
                            end else begin
                                for (int k = 0; k < NUM_DIGITS; k++) begin
                                    if (k == int'(count_q) - 1) begin
                                        digits_next[4*k +: 4] = 4'hF;
                                    end
                                end
                            end
                            count_next = count_q - CW'(1);
                        end
                    end
                    KEY_ENTER: begin
                        if (count_q != '0) begin
                            entered_next    = 1'b1;
                            pend_clear_next = 1'b1;
                        end
                    end
                    default: begin
                        code_next = acc_code;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q     <= ALL_BLANK;
            count_q      <= '0;
            code_q       <= 4'hF;
            valid_q      <= 1'b0;
            entered_q    <= 1'b0;
            pend_clear_q <= 1'b0;
        end else begin
            digits_q     <= digits_next;
            count_q      <= count_next;
            code_q       <= code_next;
            valid_q      <= accept;
            entered_q    <= entered_next;
            pend_clear_q <= pend_clear_next;
        end
    end

    assign bus.digits    = digits_q;
    assign bus.count     = count_q;
    assign bus.key_valid = valid_q;
    assign bus.key_code  = code_q;
    assign bus.entered   = entered_q;
    assign bus.full      = (count_q == FULL_COUNT);

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer: fill-mode and shift-mode instances share one
// keypad stimulus stream and are compared every cycle against a queue-based model.
module tb_keypad_entry_buffer;
    localparam int N  = 3;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    keypad_entry_buffer_if #(.NUM_DIGITS(N)) fill_if ();
    keypad_entry_buffer_if #(.NUM_DIGITS(N)) shift_if ();

    keypad_entry_buffer #(.NUM_DIGITS(N), .DEBOUNCE_CYCLES(DC), .SHIFT_MODE(0)) dut_fill (
        .clk (clk),
        .rst (rst),
        .bus (fill_if.slave)
    );

    keypad_entry_buffer #(.NUM_DIGITS(N), .DEBOUNCE_CYCLES(DC), .SHIFT_MODE(1)) dut_shift (
        .clk (clk),
        .rst (rst),
        .bus (shift_if.slave)
    );

    logic [15:0] digit_pat [10] = '{16'h0008, 16'h0080, 16'h0040, 16'h0020, 16'h0800,
                                    16'h0400, 16'h0200, 16'h8000, 16'h4000, 16'h2000};
    logic [15:0] func_pat  [3]  = '{16'h0001, 16'h0002, 16'h0004};
    logic [15:0] dead_pat  [3]  = '{16'h0010, 16'h0100, 16'h1000};

    int checks   = 0;
    int failures = 0;

    // Reference model: queues hold entered digits oldest-first.
    logic [3:0]  q_fill [$];
    logic [3:0]  q_shift [$];
    bit          pend_clear;
    bit          holding;
    int          run_len;
    logic [15:0] cand_pat;
    logic        exp_valid;
    logic        exp_entered;
    logic [3:0]  exp_code;

    int kv_seen;
    int ent_seen;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int key_of(input logic [15:0] p);
        for (int d = 0; d < 10; d++) if (p == digit_pat[d]) return d;
        for (int f = 0; f < 3; f++) if (p == func_pat[f]) return 10 + f;
        return -1;
    endfunction

    function automatic logic [11:0] model_fill_digits();
        logic [11:0] v = 12'hFFF;
        for (int k = 0; k < N; k++) if (k < q_fill.size()) v[4*k +: 4] = q_fill[k];
        return v;
    endfunction

    function automatic logic [11:0] model_shift_digits();
        logic [11:0] v = 12'hFFF;
        for (int k = 0; k < N; k++) if (k < q_shift.size()) v[4*k +: 4] = q_shift[q_shift.size() - 1 - k];
        return v;
    endfunction

    task automatic model_accept(input int key);
        exp_valid = 1'b1;
        exp_code  = 4'(key);
        if (key <= 9) begin
            if (pend_clear) begin
                q_fill.delete();
                q_shift.delete();
            end
            pend_clear = 0;
            if (q_fill.size() < N) q_fill.push_back(4'(key));
            if (q_shift.size() == N) void'(q_shift.pop_front());
            q_shift.push_back(4'(key));
        end else if (key == 10) begin
            q_fill.delete();
            q_shift.delete();
            pend_clear = 0;
        end else if (key == 11) begin
            if (q_fill.size() > 0) void'(q_fill.pop_back());
            if (q_shift.size() > 0) void'(q_shift.pop_back());
        end else if (key == 12) begin
            if (q_fill.size() > 0) begin
                exp_entered = 1'b1;
                pend_clear  = 1;
            end
        end
    endtask

    task automatic model_step(input logic [15:0] pat, input bit do_rst);
        exp_valid   = 1'b0;
        exp_entered = 1'b0;
        if (do_rst) begin
            q_fill.delete();
            q_shift.delete();
            pend_clear = 0;
            holding    = 0;
            run_len    = 0;
            exp_code   = 4'hF;
        end else if (holding) begin
            if (pat == 16'h0000) holding = 0;
        end else if (run_len > 0) begin
            if (pat == cand_pat) begin
                run_len++;
                if (run_len == DC) begin
                    model_accept(key_of(cand_pat));
                    holding = 1;
                    run_len = 0;
                end
            end else begin
                run_len = 0;
            end
        end else if (key_of(pat) >= 0) begin
            cand_pat = pat;
            run_len  = 1;
            if (run_len == DC) begin
                model_accept(key_of(cand_pat));
                holding = 1;
                run_len = 0;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] pat, input bit do_rst);
        @(negedge clk);
        fill_if.onehot  = pat;
        shift_if.onehot = pat;
        rst             = do_rst;
        @(posedge clk);
        #1;
        model_step(pat, do_rst);
        kv_seen  += int'(fill_if.key_valid);
        ent_seen += int'(fill_if.entered);
        check_output("fill_digits",   32'(fill_if.digits),    32'(model_fill_digits()));
        check_output("fill_count",    32'(fill_if.count),     32'(q_fill.size()));
        check_output("fill_full",     32'(fill_if.full),      32'(q_fill.size() == N));
        check_output("fill_valid",    32'(fill_if.key_valid), 32'(exp_valid));
        check_output("fill_code",     32'(fill_if.key_code),  32'(exp_code));
        check_output("fill_entered",  32'(fill_if.entered),   32'(exp_entered));
        check_output("shift_digits",  32'(shift_if.digits),   32'(model_shift_digits()));
        check_output("shift_count",   32'(shift_if.count),    32'(q_shift.size()));
        check_output("shift_full",    32'(shift_if.full),     32'(q_shift.size() == N));
        check_output("shift_valid",   32'(shift_if.key_valid), 32'(exp_valid));
        check_output("shift_code",    32'(shift_if.key_code), 32'(exp_code));
        check_output("shift_entered", 32'(shift_if.entered),  32'(exp_entered));
    endtask

    task automatic press(input logic [15:0] pat, input int hold, input int rel);
        for (int i = 0; i < hold; i++) apply_stimulus(pat, 1'b0);
        for (int i = 0; i < rel; i++) apply_stimulus(16'h0000, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_digits"}, 32'(fill_if.digits), 32'h0000_0FFF);
        check_output({tag, "_count"},  32'(fill_if.count), 32'd0);
        check_output({tag, "_code"},   32'(fill_if.key_code), 32'hF);
        check_output({tag, "_valid"},  32'(fill_if.key_valid), 32'd0);
        check_output({tag, "_full"},   32'(fill_if.full), 32'd0);
    endtask

    initial begin
        fill_if.onehot  = 16'h0000;
        shift_if.onehot = 16'h0000;
        kv_seen  = 0;
        ent_seen = 0;
        apply_stimulus(16'h0000, 1'b1);
        apply_stimulus(16'h0000, 1'b1);
        check_reset_values("reset");

        // Three digits into an empty buffer.
        kv_seen = 0;
        press(digit_pat[1], 6, 2);
        press(digit_pat[2], 6, 2);
        press(digit_pat[3], 6, 2);
        check_output("basic_fill_digits", 32'(fill_if.digits), 32'h321);
        check_output("basic_fill_count",  32'(fill_if.count), 32'd3);
        check_output("basic_fill_full",   32'(fill_if.full), 32'd1);
        check_output("basic_pulses",      32'(kv_seen), 32'd3);
        check_output("basic_shift_digits", 32'(shift_if.digits), 32'h123);

        // Digit into a full buffer.
        press(digit_pat[8], 6, 2);
        check_output("full_fill_digits",  32'(fill_if.digits), 32'h321);
        check_output("full_shift_digits", 32'(shift_if.digits), 32'h238);
        check_output("full_shift_count",  32'(shift_if.count), 32'd3);

        // Bouncing contact never settles for four samples.
        press(func_pat[0], 6, 2);
        kv_seen = 0;
        press(digit_pat[1], 2, 1);
        press(digit_pat[1], 2, 2);
        check_output("bounce_pulses", 32'(kv_seen), 32'd0);
        check_output("bounce_digits", 32'(fill_if.digits), 32'hFFF);
        press(digit_pat[1], 3, 0);
        check_output("bounce_early", 32'(kv_seen), 32'd0);
        press(digit_pat[1], 1, 0);
        check_output("bounce_accept", 32'(fill_if.key_valid), 32'd1);
        press(digit_pat[1], 4, 2);
        check_output("hold_no_repeat", 32'(kv_seen), 32'd1);

        // Backspace down past empty.
        press(func_pat[0], 6, 2);
        press(digit_pat[1], 6, 2);
        press(digit_pat[2], 6, 2);
        kv_seen = 0;
        press(func_pat[1], 6, 2);
        check_output("bs1_count", 32'(fill_if.count), 32'd1);
        press(func_pat[1], 6, 2);
        check_output("bs2_count", 32'(fill_if.count), 32'd0);
        press(func_pat[1], 6, 2);
        check_output("bs3_count",  32'(fill_if.count), 32'd0);
        check_output("bs3_digits", 32'(fill_if.digits), 32'hFFF);
        check_output("bs_pulses",  32'(kv_seen), 32'd3);

        // Enter then a new digit restarts the buffer.
        press(digit_pat[5], 6, 2);
        ent_seen = 0;
        press(func_pat[2], 6, 2);
        check_output("enter_pulses", 32'(ent_seen), 32'd1);
        check_output("enter_digits", 32'(fill_if.digits), 32'hFF5);
        press(digit_pat[7], 6, 2);
        check_output("after_enter_digits", 32'(fill_if.digits), 32'hFF7);
        check_output("after_enter_count",  32'(fill_if.count), 32'd1);
        press(func_pat[0], 6, 2);
        ent_seen = 0;
        press(func_pat[2], 6, 2);
        check_output("enter_empty", 32'(ent_seen), 32'd0);

        // Reset mid-debounce and mid-hold.
        press(digit_pat[4], 6, 2);
        press(digit_pat[9], 2, 0);
        apply_stimulus(digit_pat[9], 1'b1);
        check_reset_values("rst_debounce");
        apply_stimulus(16'h0000, 1'b0);
        press(digit_pat[9], 6, 0);
        apply_stimulus(digit_pat[9], 1'b1);
        check_reset_values("rst_hold");
        kv_seen = 0;
        press(16'h0000, 0, 2);
        check_output("rst_hold_quiet", 32'(kv_seen), 32'd0);
        press(digit_pat[9], 6, 2);
        check_output("repress_digits", 32'(fill_if.digits), 32'hFF9);

        // Randomised keypad activity including dead keys, chords and resets.
        for (int n = 0; n < 400; n++) begin
            int sel;
            logic [15:0] pat;
            sel = int'($urandom_range(0, 9));
            if (sel <= 4)      pat = digit_pat[$urandom_range(0, 9)];
            else if (sel == 5) pat = func_pat[$urandom_range(0, 2)];
            else if (sel == 6) pat = func_pat[$urandom_range(0, 1)];
            else if (sel == 7) pat = dead_pat[$urandom_range(0, 2)];
            else if (sel == 8) pat = 16'($urandom());
            else               pat = digit_pat[$urandom_range(0, 9)] | 16'(1 << $urandom_range(0, 15));
            if ($urandom_range(0, 40) == 0) begin
                apply_stimulus(pat, 1'b1);
            end
            press(pat, int'($urandom_range(1, 7)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_entry_buffer.md
KEYPAD_ENTRY_BUFFER -- requirements
Module: keypad_entry_buffer

Interface
REQ-001 Parameter NUM_DIGITS, default 3: number of 4-bit digit slots (1..8).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples required before a key is accepted (1..255).
REQ-003 Parameter SHIFT_MODE, default 0: 0 = fixed-position fill, 1 = calculator-style shift entry.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 onehot  input  16  raw keypad one-hot key code; 16'h0000 = no key.
REQ-007 digits  output  4*NUM_DIGITS  entered digits; nibble k = slot k; 4'hF = blank.
REQ-008 count  output  clog2(NUM_DIGITS+1)  number of non-blank slots.
REQ-009 key_valid  output  1  one-cycle pulse on every accepted key.
REQ-010 key_code  output  4  code of the last accepted key: 0-9 digit, A clear, B backspace, C enter.
REQ-011 full  output  1  high when count == NUM_DIGITS.
REQ-012 entered  output  1  one-cycle pulse on an accepted ENTER with count > 0.

Function
REQ-013 Digit map SHALL be: 0008->0, 0080->1, 0040->2, 0020->3, 0800->4, 0400->5, 0200->6, 8000->7, 4000->8, 2000->9.
REQ-014 Function map SHALL be: 0001 CLEAR, 0002 BACKSPACE, 0004 ENTER; codes 0010, 0100 and 1000, and any multi-bit or unlisted pattern, SHALL be treated as no key.
REQ-015 FSM states SHALL be IDLE, DEBOUNCE and HOLD.
REQ-016 IDLE: a mapped key SHALL latch the candidate pattern, set debounce count = 1 and go to DEBOUNCE.
REQ-017 DEBOUNCE: input equal to the candidate SHALL increment the count; any other input SHALL return the FSM to IDLE with no action.
REQ-018 On the edge where the count reaches DEBOUNCE_CYCLES, the key action SHALL apply, key_valid SHALL pulse, and the FSM SHALL go to HOLD.
REQ-019 HOLD: no further action until onehot == 0 is sampled, then go to IDLE; a held key SHALL never auto-repeat.
REQ-020 Accept latency: outputs SHALL update on the DEBOUNCE_CYCLES-th consecutive rising edge that samples the same key.
REQ-021 Digit, count < N, fill mode: slot[count] <= digit; count++.
REQ-022 Digit, count < N, shift mode: digits <= {digits << 4} with the new digit in slot 0; count++.
REQ-023 Digit, count == N: fill mode SHALL leave the buffer unchanged (key_valid still pulses); shift mode SHALL discard the oldest slot, shift, and keep count = N.
REQ-024 BACKSPACE, count > 0: fill mode SHALL blank slot[count-1]; shift mode SHALL shift right with F into the top slot; in both modes count--.
REQ-025 BACKSPACE with count == 0 SHALL change nothing.
REQ-026 CLEAR SHALL set all slots to F and count = 0.
REQ-027 ENTER with count > 0 SHALL pulse entered and hold the buffer unchanged; the next accepted digit SHALL first clear the buffer and then store itself as the first entry (count = 1).
REQ-028 ENTER with count == 0 SHALL pulse key_valid only.
REQ-029 full SHALL be a combinational function of count.

Reset
REQ-030 rst SHALL take priority over every other event, including mid-debounce and mid-HOLD.
REQ-031 On rst: FSM = IDLE, digits = all F, count = 0, key_code = 4'hF, key_valid = 0, entered = 0, and the post-ENTER clear flag and debounce counter = 0.

Verification
REQ-032 Defaults; press 0080, then 0040, then 0020, each held 6 cycles with releases between -> digits = 12'h321, count = 3, full = 1, three key_valid pulses.
REQ-033 Bounce: 0080 for 2 cycles, 0 for 1 cycle, 0080 for 2 cycles -> no key_valid and digits = 12'hFFF; 0080 held 4 cycles -> accept on the 4th sampling edge.
REQ-034 Full buffer 321 + press 4000: fill mode -> unchanged; SHIFT_MODE=1 from 1,2,3 entered -> digits = 12'h238 (oldest dropped), count = 3.
REQ-035 Buffer 21 (count 2), BACKSPACE, BACKSPACE, BACKSPACE -> count 2->1->0->0, digits = 12'hFFF, three key_valid pulses.
REQ-036 Buffer 5 + ENTER -> one entered pulse, digits = 12'hFF5; then press 7 -> digits = 12'hFF7, count = 1.
REQ-037 Assert rst during DEBOUNCE of 9 and during HOLD -> all outputs at reset values next cycle; a held key is not accepted until released and re-pressed.
